imem_loader: RTL and testbench
==============================

# imem_loader

Programming-side writer for the 16-bit instruction memory: accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words and issues single-cycle write strobes at consecutive word addresses from 0. Sits between the host/boot link and the instruction memory write port. While loading it holds the fetch stage in stall, so fetch injects NOPs (16'b0) instead of reading half-written memory.

## Interface
Parameters:
- ADDR_W, 6, instruction memory word-address width (depth = 2^ADDR_W = 64 words)
- DATA_W, 16, instruction word width; fixed at 16, byte assembly assumes two bytes per word

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse, begins a load session when idle
- byte_in  in  8  stream data byte
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  loader can accept a byte this cycle
- wr_en  out  1  instruction memory write strobe, one cycle per word
- wr_addr  out  ADDR_W  word address for wr_en
- wr_data  out  16  instruction word for wr_en
- fetch_stall  out  1  drives the fetch-stage stall input; high while busy
- busy  out  1  session in progress
- done  out  1  session finished; level, cleared by next accepted start
- err  out  1  overflow (or checksum mismatch, see Configuration); level, cleared by next accepted start
- words_written  out  ADDR_W+1  words written in current/last session

## Operation
- Session frame: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N words, each high byte then low byte.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, FINISH.
- IDLE: byte_ready=0; start -> LEN_HI, clears done, err, words_written, address counter.
- LEN_HI/LEN_LO: capture length bytes on handshake. After LEN_LO: N==0 -> FINISH, else DATA_HI.
- DATA_HI: capture high byte -> DATA_LO. DATA_LO: capture low byte; schedule write; decrement remaining; remaining==0 -> FINISH else DATA_HI.
- Handshake: byte transferred when byte_valid && byte_ready. byte_ready=1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO; 0 in IDLE, FINISH. byte_valid low = wait, no state change.
- Overflow: words beyond index 2^ADDR_W-1 are consumed (handshake continues) but not written; err set on first dropped word. Address never wraps.
- FINISH: one cycle; busy drops, done rises, -> IDLE.
- start while busy: ignored.
- Bytes offered in IDLE/FINISH: not accepted (byte_ready=0).

## Timing
- Reset values: state IDLE, byte_ready 0, wr_en 0, wr_addr 0, wr_data 0, fetch_stall 0, busy 0, done 0, err 0, words_written 0. Reset mid-session abandons it immediately; already-written words remain in memory.
- busy and fetch_stall rise the cycle after start is sampled; fall in the cycle after FINISH (same edge done rises).
- wr_en registered: asserted exactly one cycle, the cycle after the low-byte handshake; wr_addr/wr_data stable with it; words_written and address increment on that edge.
- Max throughput one byte per cycle; one word per two cycles.
- Last write strobe occurs no later than the cycle done rises; fetch_stall stays high through the last write.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: after the last word the frame carries one checksum byte = XOR of all payload bytes (length bytes excluded); extra state CHECK accepts it; mismatch sets err; done still rises. Undefined: no checksum byte, FINISH follows the last word directly; err only from overflow.

## Structure
- Shared package imem_pkg: ADDR_W/depth constants, instruction width 16, NOP encoding 16'b0, loader FSM state enum.
- One natural sub-module: imem_word_assembler (byte-pair register, high/low capture, XOR accumulator under the macro). FSM, counters and write strobe stay in imem_loader.

## Test plan
- Reset mid-session: assert rst_n=0 after LEN bytes -> all outputs reset values, next start begins clean session.
- Normal load: start, bytes 00 03, 12 34, AB CD, 00 01 -> writes 0x1234@0, 0xABCD@1, 0x0001@2, each wr_en one cycle; done=1, words_written=3, err=0.
- Zero length: start, 00 00 -> no wr_en, done one cycle after LEN_LO, words_written=0.
- Backpressure/gaps: byte_valid toggled randomly on same 3-word frame -> identical writes; no state change while byte_valid=0.
- Overflow: N=66 words -> 64 writes (addr 0..63), last 2 words consumed unwritten, err=1, words_written=64, done=1.
- start while busy -> ignored; with IMEM_LOADER_CHECKSUM_EN, wrong checksum byte after 12 34 -> err=1, done=1; correct (0x26) -> err=0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants and loader FSM state encoding for the 16-bit instruction memory.
// Optional feature macro used by the loader bundle: IMEM_LOADER_CHECKSUM_EN.
package imem_pkg;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int DATA_W = 16;

    localparam logic [DATA_W-1:0] NOP = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CHECK,
        ST_FINISH
    } load_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port between host link and loader.
// The host/bench side uses the master modport; the loader uses the slave modport.
interface imem_loader_if;
    import imem_pkg::*;

    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/imem_word_assembler.sv
// Holds the high byte of the word in flight and presents {high, incoming low} as the word.
// With IMEM_LOADER_CHECKSUM_EN it also keeps a running XOR of every payload byte.
module imem_word_assembler
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              cap_hi_i,
`ifdef IMEM_LOADER_CHECKSUM_EN
    input  logic              cap_lo_i,
    output logic [7:0]        csum_o,
`endif
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o
);

    logic [7:0] hi_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
        end else if (clear_i) begin
            hi_q <= '0;
        end else if (cap_hi_i) begin
            hi_q <= byte_i;
        end
    end

    // The low byte is used straight from the stream so the word is ready on the handshake cycle.
    assign word_o = {hi_q, byte_i};

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (clear_i) begin
            csum_q <= '0;
        end else if (cap_hi_i || cap_lo_i) begin
            csum_q <= csum_q ^ byte_i;
        end
    end

    assign csum_o = csum_q;
`endif

endmodule

// File: rtl/imem_loader.sv
// Boot-link loader: parses LEN_HI, LEN_LO, N big-endian words and writes them from address 0
// while holding fetch in stall. IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    imem_loader_if.slave      bus,
    output logic              fetch_stall,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_written
);

    load_state_e       state_q, state_d;
    logic [15:0]       remaining_q, remaining_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              byte_ready;
    logic              hs;
    logic              clear;
    logic              cap_hi;
    logic              cap_lo;
    logic [DATA_W-1:0] word;
    logic [15:0]       len_word;
    logic              mem_full;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    imem_word_assembler u_asm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (clear),
        .cap_hi_i (cap_hi),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .cap_lo_i (cap_lo),
        .csum_o   (csum),
`endif
        .byte_i   (bus.byte_in),
        .word_o   (word)
    );

    assign hs       = bus.byte_valid && byte_ready;
    assign len_word = {remaining_q[15:8], bus.byte_in};
    // The counter saturates at DEPTH, so its top bit alone marks a full memory.
    assign mem_full = cnt_q[ADDR_W];

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        err_d       = err_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        byte_ready  = 1'b0;
        clear       = 1'b0;
        cap_hi      = 1'b0;
        cap_lo      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_LEN_HI;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    clear   = 1'b1;
                end
            end
            ST_LEN_HI: begin
                byte_ready = 1'b1;
                if (hs) begin
                    remaining_d = {bus.byte_in, 8'h00};
                    state_d     = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                byte_ready = 1'b1;
                if (hs) begin
                    remaining_d = len_word;
                    if (len_word == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_FINISH;
`endif
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                byte_ready = 1'b1;
                if (hs) begin
                    cap_hi  = 1'b1;
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                byte_ready = 1'b1;
                if (hs) begin
                    cap_lo      = 1'b1;
                    remaining_d = remaining_q - 16'd1;
                    if (!mem_full) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cnt_q[ADDR_W-1:0];
                        wr_data_d = word;
                        cnt_d     = cnt_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (remaining_q == 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_FINISH;
`endif
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                byte_ready = 1'b1;
                if (hs) begin
                    if (bus.byte_in != csum) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_FINISH;
                end
            end
`endif
            ST_FINISH: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= NOP;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign bus.byte_ready = byte_ready;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;

    // FINISH still counts as busy so the final write strobe lands under stall.
    assign busy          = (state_q != ST_IDLE);
    assign fetch_stall   = busy;
    assign done          = done_q;
    assign err           = err_q;
    assign words_written = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: a frame-level model predicts writes and status.
// Honors IMEM_LOADER_CHECKSUM_EN by appending the XOR checksum byte to every frame.
module tb_imem_loader;
    import imem_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk;
    logic rst_n;
    logic fetch_stall, busy, done, err;
    logic [ADDR_W:0] words_written;

    int vectors;
    int miscompares;
    int gap_max;

    wr_t         exp_q[$];
    logic [15:0] frame_words[$];

    imem_loader_if bus ();

    imem_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .fetch_stall   (fetch_stall),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .words_written (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest predicted write.
    always @(negedge clk) begin
        if (rst_n && bus.wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_wr: addr 0x%0h data 0x%0h, expected no write",
                         bus.wr_addr, bus.wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                check("wr_data", 32'(bus.wr_data), 32'(e.data));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send_byte(input logic [7:0] b);
        int gap;
        int t;
        gap = $urandom_range(0, gap_max);
        bus.byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        t = 0;
        while (bus.byte_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_ready_timeout: byte 0x%0h not accepted within 50 cycles", b);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.byte_in    = $urandom_range(0, 255);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_stall", 32'(fetch_stall), 32'd1);
        check("start_done_clr", 32'(done), 32'd0);
        check("start_err_clr", 32'(err), 32'd0);
        check("start_ww_clr", 32'(words_written), 32'd0);
    endtask

    // Sends one whole frame built from frame_words and checks the session outcome.
    task automatic run_frame(input bit poke_start, input bit bad_csum);
        int          n;
        int          exp_ww;
        logic [15:0] nn;
        logic [15:0] w;
        logic [7:0]  csum;
        bit          exp_err;
        n      = frame_words.size();
        nn     = 16'(n);
        exp_ww = (n > DEPTH) ? DEPTH : n;
        exp_err = (n > DEPTH);
        csum   = 8'h00;

        do_start();
        send_byte(nn[15:8]);
        if (poke_start) begin
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        send_byte(nn[7:0]);
        for (int i = 0; i < n; i++) begin
            wr_t e;
            w = frame_words[i];
            csum = csum ^ w[15:8] ^ w[7:0];
            send_byte(w[15:8]);
            if (i < DEPTH) begin
                e.addr = ADDR_W'(i);
                e.data = w;
                exp_q.push_back(e);
            end
            send_byte(w[7:0]);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(bad_csum ? (csum ^ 8'h5A) : csum);
        exp_err = exp_err || bad_csum;
`else
        if (bad_csum) exp_err = exp_err;
`endif
        check("finish_busy", 32'(busy), 32'd1);
        check("finish_not_done", 32'(done), 32'd0);
        @(negedge clk);
        check("end_done", 32'(done), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_stall", 32'(fetch_stall), 32'd0);
        check("end_words_written", 32'(words_written), 32'(exp_ww));
        check("end_err", 32'(err), 32'(exp_err));
        #1;
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        gap_max        = 0;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_wr_data", 32'(bus.wr_data), 32'd0);
        check("rst_stall", 32'(fetch_stall), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ww", 32'(words_written), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Bytes offered while idle are refused.
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'h77;
        repeat (3) @(negedge clk);
        check("idle_ready", 32'(bus.byte_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        bus.byte_valid = 1'b0;

        // Reset in the middle of a session.
        do_start();
        send_byte(8'h00);
        send_byte(8'h03);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(bus.byte_ready), 32'd0);
        check("mid_rst_stall", 32'(fetch_stall), 32'd0);
        check("mid_rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("mid_rst_ww", 32'(words_written), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Normal three-word load, back to back.
        frame_words = '{16'h1234, 16'hABCD, 16'h0001};
        run_frame(1'b0, 1'b0);

        // Zero-length frame.
        frame_words.delete();
        run_frame(1'b0, 1'b0);

        // Same frame with random valid gaps.
        gap_max = 3;
        frame_words = '{16'h1234, 16'hABCD, 16'h0001};
        run_frame(1'b0, 1'b0);

        // Overflow: 66 words into a 64-word memory.
        gap_max = 1;
        frame_words.delete();
        for (int i = 0; i < DEPTH + 2; i++) frame_words.push_back(16'($urandom));
        run_frame(1'b0, 1'b0);

        // Random frames; one carries a start pulse mid-session that must be ignored.
        gap_max = 2;
        for (int f = 0; f < 6; f++) begin
            frame_words.delete();
            for (int i = 0; i < int'($urandom_range(1, 12)); i++)
                frame_words.push_back(16'($urandom));
            run_frame(f == 2, 1'b0);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        gap_max = 0;
        frame_words = '{16'h1234};
        run_frame(1'b0, 1'b1);
        frame_words = '{16'h1234};
        run_frame(1'b0, 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
